ticket_ram_arbiter: RTL

- Shares the single ticket-RAM command port (operation / index / data in; over / wrong / num / data out) between N_REQ requester sub-menus, e.g. customer purchase, manager ticket browse/income/clear, and manager movie.
- Round-robin arbitration; a grant is held for one complete RAM transaction.
- The RAM result is returned to the granted requester with a one-cycle done pulse.
- A transaction that never completes is aborted by a watchdog.
- Sits between the menu modules and the ticket RAM; the RAM itself is unchanged.

---
 rtl/ticket_ram_pkg.sv | 37 +++
 rtl/ticket_ram_arbiter_rr_pick.sv | 33 +++
 rtl/ticket_ram_arbiter.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/ticket_ram_pkg.sv
// Shared definitions for the ticket RAM command port: operation encodings,
// port widths and the field layout of a 65-bit ticket record.
package ticket_ram_pkg;

   localparam int TR_OP_W  = 3;
   localparam int TR_IDX_W = 32;
   localparam int TR_DAT_W = 65;

   typedef enum logic [2:0] {
      OP_IDLE      = 3'b000,
      OP_NEW       = 3'b001,
      OP_READ_ID   = 3'b010,
      OP_CHANGE_ID = 3'b011,
      OP_DELETE_ID = 3'b100,
      OP_READ_IDX  = 3'b101,
      OP_CLEAR_ALL = 3'b111
   } ticket_op_e;

   // Ticket record layout, most significant field first
   localparam int REC_STATE_HI = 64;
   localparam int REC_STATE_LO = 62;
   localparam int REC_ID_HI    = 61;
   localparam int REC_ID_LO    = 30;
   localparam int REC_INFO_HI  = 29;
   localparam int REC_INFO_LO  = 0;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_BUSY    = 2'd1,
      ST_RELEASE = 2'd2
   } arb_state_e;

   function automatic logic op_is_idle(input logic [TR_OP_W-1:0] op);
      return (op == OP_IDLE);
   endfunction

endpackage

// File: rtl/ticket_ram_arbiter_rr_pick.sv
// Combinational round-robin picker: first requesting slot at or after ptr_i,
// wrapping modulo N, as a one-hot grant plus its index.
module rr_pick #(
   parameter int N     = 3,
   parameter int PTR_W = $clog2(N)
) (
   input  logic [N-1:0]     req_i,
   input  logic [PTR_W-1:0] ptr_i,
   output logic [N-1:0]     gnt_o,
   output logic [PTR_W-1:0] idx_o,
   output logic             vld_o
);

   // Scan from the pointer; only the first hit is taken
   always_comb begin : pick_blk
      int   j;
      logic hit;
      gnt_o = '0;
      idx_o = '0;
      vld_o = 1'b0;
      j     = 0;
      hit   = 1'b0;
      for (int i = 0; i < N; i++) begin
         j = int'(ptr_i) + i;
         j = (j >= N) ? (j - N) : j;
         hit = !vld_o && req_i[j];
         gnt_o[j] = gnt_o[j] | hit;
         idx_o = hit ? PTR_W'(j) : idx_o;
         vld_o = vld_o | hit;
      end
   end

endmodule

// File: rtl/ticket_ram_arbiter.sv
// Round-robin arbiter sharing the single ticket-RAM command port between the
// menu requesters; one grant covers one full RAM transaction, guarded by a watchdog.
module ticket_ram_arbiter
   import ticket_ram_pkg::*;
#(
   parameter int N_REQ   = 3,
   parameter int TIMEOUT = 1024,
   parameter int OP_W    = TR_OP_W,
   parameter int IDX_W   = TR_IDX_W,
   parameter int DAT_W   = TR_DAT_W
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [N_REQ*OP_W-1:0]    req_op_i,
   input  logic [N_REQ*IDX_W-1:0]   req_index_i,
   input  logic [N_REQ*DAT_W-1:0]   req_data_i,
   output logic [N_REQ-1:0]         gnt_o,
   output logic [N_REQ-1:0]         done_o,
   output logic                     wrong_o,
   output logic                     timeout_o,
   output logic [DAT_W-1:0]         rdata_o,
   output logic [31:0]              num_o,
   output logic                     busy_o,
   output logic [OP_W-1:0]          ram_op_o,
   output logic [IDX_W-1:0]         ram_index_o,
   output logic [DAT_W-1:0]         ram_data_o,
   input  logic                     ram_over_i,
   input  logic                     ram_wrong_i,
   input  logic [31:0]              ram_num_i,
   input  logic [DAT_W-1:0]         ram_data_i
);

   localparam int PTR_W = $clog2(N_REQ);
   localparam int WD_W  = $clog2(TIMEOUT);
   localparam logic [OP_W-1:0] OP_NONE = OP_W'(OP_IDLE);
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(N_REQ - 1);

   arb_state_e          state_q, state_d;
   logic [PTR_W-1:0]    ptr_q, ptr_d;
   logic [PTR_W-1:0]    gidx_q, gidx_d;
   logic [WD_W-1:0]     wd_q, wd_d;
   logic [N_REQ-1:0]    gnt_q, gnt_d;
   logic [N_REQ-1:0]    done_q, done_d;
   logic                wrong_q, wrong_d;
   logic                tmo_q, tmo_d;
   logic [DAT_W-1:0]    rdata_q, rdata_d;
   logic [OP_W-1:0]     op_q, op_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [DAT_W-1:0]    dat_q, dat_d;

   logic [N_REQ-1:0]    req_s;
   logic [N_REQ-1:0]    pick_gnt_s;
   logic [PTR_W-1:0]    pick_idx_s;
   logic                pick_vld_s;
   logic [OP_W-1:0]     own_op_s;

   for (genvar k = 0; k < N_REQ; k++) begin : g_req
      assign req_s[k] = (req_op_i[k*OP_W +: OP_W] != OP_NONE);
   end

   rr_pick #(
      .N     (N_REQ),
      .PTR_W (PTR_W)
   ) u_pick (
      .req_i (req_s),
      .ptr_i (ptr_q),
      .gnt_o (pick_gnt_s),
      .idx_o (pick_idx_s),
      .vld_o (pick_vld_s)
   );

   assign own_op_s = req_op_i[gidx_q*OP_W +: OP_W];

   // Next-state, latching and completion capture for the grant FSM
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      gidx_d  = gidx_q;
      wd_d    = wd_q;
      gnt_d   = gnt_q;
      done_d  = '0;
      wrong_d = wrong_q;
      tmo_d   = tmo_q;
      rdata_d = rdata_q;
      op_d    = op_q;
      idx_d   = idx_q;
      dat_d   = dat_q;
      case (state_q)
         ST_IDLE: begin
            if (pick_vld_s) begin
               op_d    = req_op_i[pick_idx_s*OP_W +: OP_W];
               idx_d   = req_index_i[pick_idx_s*IDX_W +: IDX_W];
               dat_d   = req_data_i[pick_idx_s*DAT_W +: DAT_W];
               gnt_d   = pick_gnt_s;
               gidx_d  = pick_idx_s;
               ptr_d   = (pick_idx_s == PTR_LAST) ? '0 : (pick_idx_s + PTR_W'(1));
               wd_d    = '0;
               state_d = ST_BUSY;
            end else begin
               op_d    = OP_NONE;
            end
         end
         ST_BUSY: begin
            wd_d = wd_q + WD_W'(1);
            // A completion seen on the final watchdog cycle still counts as success
            if (ram_over_i) begin
               rdata_d = ram_data_i;
               wrong_d = ram_wrong_i;
               tmo_d   = 1'b0;
               done_d  = gnt_q;
               op_d    = OP_NONE;
               state_d = ST_RELEASE;
            end else if (wd_q == WD_LAST) begin
               wrong_d = 1'b1;
               tmo_d   = 1'b1;
               done_d  = gnt_q;
               op_d    = OP_NONE;
               state_d = ST_RELEASE;
            end else begin
               state_d = ST_BUSY;
            end
         end
         ST_RELEASE: begin
            op_d = OP_NONE;
            // Wait for the RAM and the owner to both go quiet so nothing is re-issued
            if (!ram_over_i && (own_op_s == OP_NONE)) begin
               gnt_d   = '0;
               state_d = ST_IDLE;
            end else begin
               state_d = ST_RELEASE;
            end
         end
         default: begin
            op_d    = OP_NONE;
            gnt_d   = '0;
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and output registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         ptr_q   <= '0;
         gidx_q  <= '0;
         wd_q    <= '0;
         gnt_q   <= '0;
         done_q  <= '0;
         wrong_q <= 1'b0;
         tmo_q   <= 1'b0;
         rdata_q <= '0;
         op_q    <= OP_NONE;
         idx_q   <= '0;
         dat_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         gidx_q  <= gidx_d;
         wd_q    <= wd_d;
         gnt_q   <= gnt_d;
         done_q  <= done_d;
         wrong_q <= wrong_d;
         tmo_q   <= tmo_d;
         rdata_q <= rdata_d;
         op_q    <= op_d;
         idx_q   <= idx_d;
         dat_q   <= dat_d;
      end
   end

   assign gnt_o       = gnt_q;
   assign done_o      = done_q;
   assign wrong_o     = wrong_q;
   assign timeout_o   = tmo_q;
   assign rdata_o     = rdata_q;
   assign busy_o      = (state_q != ST_IDLE);
   assign ram_op_o    = op_q;
   assign ram_index_o = idx_q;
   assign ram_data_o  = dat_q;
   assign num_o       = ram_num_i;

endmodule
